// File: rtl/rename_pkg.sv
// Shared defaults and register-index types for the rename stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rename_pkg;

   localparam int DEF_NUM_ARCH = 32;
   localparam int DEF_NUM_PHYS = 64;
   localparam int DEF_WIDTH    = 2;
   localparam int DEF_AW       = $clog2(DEF_NUM_ARCH);
   localparam int DEF_PW       = $clog2(DEF_NUM_PHYS);

   typedef logic [DEF_AW-1:0] areg_t;
   typedef logic [DEF_PW-1:0] preg_t;

endpackage

// File: rtl/rename_stage_if.sv
// Decode-side input group, dispatch-side output group and retire port of the rename stage.
// Latency: n/a (wires only).
// Backpressure: in_ready/in_valid upstream, out_valid/out_ready downstream; retire port is never stalled.
// Ports: in_* (decoded group), out_* (renamed group), ret_* (freed registers), free_count.
interface rename_stage_if
   import rename_pkg::*;
#(
   parameter int NUM_ARCH = DEF_NUM_ARCH,
   parameter int NUM_PHYS = DEF_NUM_PHYS,
   parameter int WIDTH    = DEF_WIDTH
) ();
   localparam int AW = $clog2(NUM_ARCH);
   localparam int PW = $clog2(NUM_PHYS);

   logic [WIDTH-1:0]         in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0][AW-1:0] in_rs1;
   logic [WIDTH-1:0][AW-1:0] in_rs2;
   logic [WIDTH-1:0][AW-1:0] in_rd;
   logic [WIDTH-1:0]         in_has_rd;
   logic [WIDTH-1:0]         out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0][PW-1:0] out_ps1;
   logic [WIDTH-1:0][PW-1:0] out_ps2;
   logic [WIDTH-1:0][PW-1:0] out_pd;
   logic [WIDTH-1:0][PW-1:0] out_old_pd;
   logic [WIDTH-1:0]         ret_valid;
   logic [WIDTH-1:0][PW-1:0] ret_pd;
   logic [PW:0]              free_count;

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_has_rd, out_ready, ret_valid, ret_pd,
      input  in_ready, out_valid, out_ps1, out_ps2, out_pd, out_old_pd, free_count
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_has_rd, out_ready, ret_valid, ret_pd,
      output in_ready, out_valid, out_ps1, out_ps2, out_pd, out_old_pd, free_count
   );

endinterface

// File: rtl/rename_stage_free_list.sv
// Circular free list of physical registers: WIDTH pops from head, WIDTH pushes at tail.
// Latency: pop data is combinational from head; pushes become visible after the edge.
// Backpressure: none; caller must keep pop_n_i <= count_o and never overflow.
// Ports: pop_n_i/pop_dat_o (pop port), push_vld_i/push_dat_i (push port), count_o (occupancy).
module free_list
   import rename_pkg::*;
#(
   parameter int NUM_ARCH = DEF_NUM_ARCH,
   parameter int NUM_PHYS = DEF_NUM_PHYS,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PW       = $clog2(NUM_PHYS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PW:0]              pop_n_i,
   output logic [WIDTH-1:0][PW-1:0] pop_dat_o,
   input  logic [WIDTH-1:0]         push_vld_i,
   input  logic [WIDTH-1:0][PW-1:0] push_dat_i,
   output logic [PW:0]              count_o
);
   localparam int DEPTH = NUM_PHYS - NUM_ARCH;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] mem_q [DEPTH];
   logic [IW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW:0]   count_q, count_d;
   logic [IW-1:0] push_idx [WIDTH];

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
      return IW'((int'(p) + k) % DEPTH);
   endfunction

   always_comb begin
      int n;
      n = 0;
      for (int k = 0; k < WIDTH; k++) begin
         pop_dat_o[k] = mem_q[wrap(head_q, k)];
      end
      // Valid pushes are packed toward the tail in slot order, skipping holes.
      for (int i = 0; i < WIDTH; i++) begin
         push_idx[i] = wrap(tail_q, n);
         if (push_vld_i[i]) n++;
      end
      head_d  = wrap(head_q, int'(pop_n_i));
      tail_d  = wrap(tail_q, n);
      count_d = count_q + (PW+1)'(n) - pop_n_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= PW'(NUM_ARCH + i);
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= (PW+1)'(DEPTH);
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (push_vld_i[i]) mem_q[push_idx[i]] <= push_dat_i[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/rename_stage.sv
// Renames up to WIDTH instructions per cycle: RAT lookup, intra-group bypass, free-list allocation.
// Latency: 1 cycle, outputs registered on the accept edge.
// Backpressure: whole group held off unless output slot frees and enough physical registers exist.
// Ports: clk, rst_n (async, active-low), bus (in_*, out_*, ret_*, free_count).
module rename_stage
   import rename_pkg::*;
#(
   parameter int NUM_ARCH = DEF_NUM_ARCH,
   parameter int NUM_PHYS = DEF_NUM_PHYS,
   parameter int WIDTH    = DEF_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   rename_stage_if.slave bus
);
   localparam int PW = $clog2(NUM_PHYS);

   logic [PW-1:0]            rat_q [NUM_ARCH];
   logic [PW-1:0]            rat_d [NUM_ARCH];
   logic [WIDTH-1:0]         alloc;
   logic [PW:0]              need, pop_n, free_count;
   logic                     in_ready, accept;
   logic [WIDTH-1:0]         ret_vld;
   logic [WIDTH-1:0][PW-1:0] pop_dat, pd, ps1, ps2, old_pd;

   logic [WIDTH-1:0]         out_valid_q, out_valid_d;
   logic [WIDTH-1:0][PW-1:0] out_ps1_q, out_ps1_d, out_ps2_q, out_ps2_d;
   logic [WIDTH-1:0][PW-1:0] out_pd_q, out_pd_d, out_old_pd_q, out_old_pd_d;

   always_comb begin
      int n;
      n = 0;
      for (int i = 0; i < WIDTH; i++) begin
         alloc[i] = bus.in_valid[i] & bus.in_has_rd[i] & (bus.in_rd[i] != '0);
      end
      // Allocating slots take consecutive free-list entries in slot order.
      for (int i = 0; i < WIDTH; i++) begin
         pd[i] = '0;
         if (alloc[i]) begin
            for (int k = 0; k < WIDTH; k++) begin
               if (k == n) pd[i] = pop_dat[k];
            end
            n++;
         end
      end
      need = (PW+1)'(n);
      // Ascending scan over older slots leaves the youngest writer's pd in place.
      for (int i = 0; i < WIDTH; i++) begin
         ps1[i]    = (bus.in_rs1[i] == '0) ? '0 : rat_q[bus.in_rs1[i]];
         ps2[i]    = (bus.in_rs2[i] == '0) ? '0 : rat_q[bus.in_rs2[i]];
         old_pd[i] = alloc[i] ? rat_q[bus.in_rd[i]] : '0;
         for (int j = 0; j < i; j++) begin
            if (alloc[j] && bus.in_rd[j] == bus.in_rs1[i]) ps1[i] = pd[j];
            if (alloc[j] && bus.in_rd[j] == bus.in_rs2[i]) ps2[i] = pd[j];
            if (alloc[i] && alloc[j] && bus.in_rd[j] == bus.in_rd[i]) old_pd[i] = pd[j];
         end
      end
   end

   assign in_ready = ((out_valid_q == '0) || bus.out_ready) && (free_count >= need);
   assign accept   = in_ready && (bus.in_valid != '0);
   assign pop_n    = accept ? need : '0;

   always_comb begin
      rat_d = rat_q;
      if (accept) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (alloc[i]) rat_d[bus.in_rd[i]] = pd[i];
         end
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_ps1_d    = out_ps1_q;
      out_ps2_d    = out_ps2_q;
      out_pd_d     = out_pd_q;
      out_old_pd_d = out_old_pd_q;
      if (accept) begin
         out_valid_d  = bus.in_valid;
         out_ps1_d    = ps1;
         out_ps2_d    = ps2;
         out_pd_d     = pd;
         out_old_pd_d = old_pd;
      end else if (bus.out_ready) begin
         out_valid_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_ARCH; r++) rat_q[r] <= PW'(r);
         out_valid_q  <= '0;
         out_ps1_q    <= '0;
         out_ps2_q    <= '0;
         out_pd_q     <= '0;
         out_old_pd_q <= '0;
      end else begin
         rat_q        <= rat_d;
         out_valid_q  <= out_valid_d;
         out_ps1_q    <= out_ps1_d;
         out_ps2_q    <= out_ps2_d;
         out_pd_q     <= out_pd_d;
         out_old_pd_q <= out_old_pd_d;
      end
   end

   // p0 is never on the free list, so retiring it is dropped.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) ret_vld[i] = bus.ret_valid[i] && (bus.ret_pd[i] != '0);
   end

   free_list #(.NUM_ARCH(NUM_ARCH), .NUM_PHYS(NUM_PHYS), .WIDTH(WIDTH), .PW(PW)) u_free_list (
      .clk        (clk),
      .rst_n      (rst_n),
      .pop_n_i    (pop_n),
      .pop_dat_o  (pop_dat),
      .push_vld_i (ret_vld),
      .push_dat_i (bus.ret_pd),
      .count_o    (free_count)
   );

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_ps1    = out_ps1_q;
   assign bus.out_ps2    = out_ps2_q;
   assign bus.out_pd     = out_pd_q;
   assign bus.out_old_pd = out_old_pd_q;
   assign bus.free_count = free_count;

endmodule
